// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers.
package mips_pipe_pkg;

    // Entries held in a skid-buffered pipeline register.
    localparam int unsigned OCC_W = 2;

    // Encoding matches occupancy so the count is a direct state decode.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/flopenr_async.sv
// Data flop with load enable and asynchronous active-low clear.
module flopenr_async #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled; clear immediately on reset low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register between MIPS stages.
// in_ready is a pure state decode, so a downstream stall reaches upstream
// one cycle late; the skid register absorbs the word accepted meanwhile.
module pipe_skid_reg
    import mips_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    skid_state_t      state;
    skid_state_t      state_nxt;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    // State register; reset empties the buffer immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, register load controls and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        main_d    = in_data;
        out_valid = 1'b0;
        in_ready  = 1'b1;
        occupancy = '0;

        unique case (state)
            EMPTY: begin
                if (in_valid) begin
                    main_en   = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                out_valid = 1'b1;
                occupancy = OCC_W'(1);
                if (in_valid && out_ready) begin
                    main_en = 1'b1;
                end else if (in_valid) begin
                    skid_en   = 1'b1;
                    state_nxt = FULL;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
                occupancy = OCC_W'(2);
                main_d    = skid_q;
                if (out_ready) begin
                    main_en   = 1'b1;
                    state_nxt = ONE;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase

        // Flush overrides everything; stored data is left as-is.
        if (flush) begin
            state_nxt = EMPTY;
            main_en   = 1'b0;
            skid_en   = 1'b0;
        end
    end

    flopenr_async #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (out_data)
    );

    flopenr_async #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed vector table, async
// reset sequence, and a random valid/ready run against a FIFO scoreboard.
module tb_pipe_skid_reg;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    int n_cmp;
    int n_bad;

    pipe_skid_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] din;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_dout;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ov, input logic ir,
                              input logic [31:0] dout, input logic [1:0] occ);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        check({tag, ".out_data"},  out_data,       dout);
        check({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    endtask

    function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [31:0] din,
                                logic ov, logic ir, logic [31:0] dout, logic [1:0] occ);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.din = din;
        v.e_ov = ov; v.e_ir = ir; v.e_dout = dout; v.e_occ = occ;
        return v;
    endfunction

    // Random-phase scoreboard state
    logic [31:0] sb[$];
    logic        prev_stall_out;
    logic [31:0] prev_out_data;
    logic        hold_in;
    logic [31:0] exp_word;

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Stream
        vecs.push_back(mk(1, 1, 0, 32'h11, 1, 1, 32'h11, 1));
        vecs.push_back(mk(1, 1, 0, 32'h22, 1, 1, 32'h22, 1));
        vecs.push_back(mk(1, 1, 0, 32'h33, 1, 1, 32'h33, 1));
        vecs.push_back(mk(0, 1, 0, 32'h00, 0, 1, 32'h33, 0));
        // Stall fill, CC held off, then AA, BB, CC in order
        vecs.push_back(mk(1, 1, 0, 32'hAA, 1, 1, 32'hAA, 1));
        vecs.push_back(mk(1, 0, 0, 32'hBB, 1, 0, 32'hAA, 2));
        vecs.push_back(mk(1, 0, 0, 32'hCC, 1, 0, 32'hAA, 2));
        vecs.push_back(mk(1, 1, 0, 32'hCC, 1, 1, 32'hBB, 1));
        vecs.push_back(mk(1, 1, 0, 32'hCC, 1, 1, 32'hCC, 1));
        vecs.push_back(mk(0, 1, 0, 32'h00, 0, 1, 32'hCC, 0));
        // Drain from FULL
        vecs.push_back(mk(1, 0, 0, 32'hAA, 1, 1, 32'hAA, 1));
        vecs.push_back(mk(1, 0, 0, 32'hBB, 1, 0, 32'hAA, 2));
        vecs.push_back(mk(0, 1, 0, 32'h00, 1, 1, 32'hBB, 1));
        vecs.push_back(mk(0, 1, 0, 32'h00, 0, 1, 32'hBB, 0));
        vecs.push_back(mk(0, 1, 0, 32'h00, 0, 1, 32'hBB, 0));
        // Flush from FULL with out_ready, then DD alone
        vecs.push_back(mk(1, 0, 0, 32'h01, 1, 1, 32'h01, 1));
        vecs.push_back(mk(1, 0, 0, 32'h02, 1, 0, 32'h01, 2));
        vecs.push_back(mk(1, 1, 1, 32'h03, 0, 1, 32'h01, 0));
        vecs.push_back(mk(1, 1, 0, 32'hDD, 1, 1, 32'hDD, 1));
        vecs.push_back(mk(0, 1, 0, 32'h00, 0, 1, 32'hDD, 0));
        // Flush from ONE drops the same-cycle input
        vecs.push_back(mk(1, 0, 0, 32'h44, 1, 1, 32'h44, 1));
        vecs.push_back(mk(1, 1, 1, 32'h55, 0, 1, 32'h44, 0));
        // Fill to FULL for the async reset sequence
        vecs.push_back(mk(1, 0, 0, 32'h66, 1, 1, 32'h66, 1));
        vecs.push_back(mk(1, 0, 0, 32'h77, 1, 0, 32'h66, 2));

        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #3;
        check_outs("reset", 1'b0, 1'b1, 32'h0, 2'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            in_data   = vecs[i].din;
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir,
                       vecs[i].e_dout, vecs[i].e_occ);
        end

        // Async reset mid-cycle while FULL: outputs clear before the next edge
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b1, 32'h0, 2'd0);
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h88;
        @(posedge clk);
        #1;
        check_outs("post_rst", 1'b1, 1'b1, 32'h88, 2'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outs("post_rst_drain", 1'b0, 1'b1, 32'h88, 2'd0);

        // Random valid/ready with FIFO scoreboard
        prev_stall_out = 1'b0;
        prev_out_data  = '0;
        hold_in        = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!hold_in) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            check("rnd.occupancy", 32'(occupancy), 32'(sb.size()));
            if (prev_stall_out) begin
                check("rnd.out_hold_valid", 32'(out_valid), 32'd1);
                check("rnd.out_hold_data", out_data, prev_out_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("rnd.unexpected_out", out_data, 32'hFFFF_FFFF ^ out_data);
                end else begin
                    exp_word = sb.pop_front();
                    check("rnd.out_data", out_data, exp_word);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
            end
            hold_in        = in_valid && !in_ready;
            prev_stall_out = out_valid && !out_ready;
            prev_out_data  = out_data;
            @(posedge clk);
            #1;
        end

        // Drain remaining words
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("drain.extra", out_data, 32'hFFFF_FFFF ^ out_data);
                end else begin
                    exp_word = sb.pop_front();
                    check("drain.out_data", out_data, exp_word);
                end
            end
            @(posedge clk);
            #1;
        end
        check("drain.left", 32'(sb.size()), 32'd0);
        check("drain.occupancy", 32'(occupancy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Two-entry skid-buffered pipeline register with a valid/ready handshake on both sides, placed between MIPS pipeline stages, e.g. IF/ID and ID/EX. It accepts a word from the upstream stage, holds it, and presents it to the downstream stage. A stall from downstream is absorbed one cycle later without a combinational ready path back to upstream. A synchronous flush empties it for branch/jump squashing.

## Interface
- WIDTH, 32, payload width in bits
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; low clears all state immediately
- flush  input  1  synchronous squash; discards all held entries
- in_valid  input  1  upstream presents in_data
- in_ready  output  1  block can accept; registered, depends only on state
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  downstream consumes out_data this cycle
- out_data  output  WIDTH  oldest held payload; driven from a register
- occupancy  output  2  entries held: 0, 1 or 2

## Operation
- Handshake rules:
  - A transfer occurs on a rising edge where valid and ready are both 1.
  - Upstream holds in_data stable while in_valid=1 and in_ready=0.
  - The block keeps out_data stable while out_valid=1 and out_ready=0.
- Storage: main register (drives out_data) and skid register.
- States:
  - EMPTY (occupancy 0): out_valid=0, in_ready=1.
  - ONE (occupancy 1): out_valid=1, in_ready=1.
  - FULL (occupancy 2): out_valid=1, in_ready=0.
- Transitions (flush=0):
  - EMPTY, in_valid=1: main<=in_data, go to ONE. With in_valid=0, stay.
  - ONE, in_valid=1 and out_ready=1: main<=in_data, stay in ONE (pass-through at full rate).
  - ONE, in_valid=0 and out_ready=1: go to EMPTY.
  - ONE, in_valid=1 and out_ready=0: skid<=in_data, go to FULL.
  - ONE, in_valid=0 and out_ready=0: stay.
  - FULL, out_ready=1: main<=skid, go to ONE. in_valid is ignored because in_ready=0.
  - FULL, out_ready=0: stay.
- flush=1 has the highest priority. Next state is EMPTY regardless of in_valid/out_ready.
  - A same-cycle input handshake counts as accepted and is dropped.
  - A same-cycle output handshake counts as consumed.
  - main and skid contents are left unchanged.
- Ordering is strict FIFO. No entry is duplicated or lost except by flush.

## Timing
- Reset (reset=0), asynchronous: state EMPTY, main=0, skid=0. Outputs: out_valid=0, in_ready=1, out_data=0, occupancy=0.
- Reset is released synchronously by the system. The first transfer can occur on the first rising edge with reset=1.
- Reset mid-operation: all held entries are lost immediately, with no partial output.
- Latency: data accepted on edge N appears on out_data with out_valid=1 after edge N.
- Throughput: 1 word/cycle in steady state with out_ready=1.
- in_ready drops one cycle after the first stall. The skid register captures the word accepted in that cycle.
- Every output is a register output or a decode of state only. There is no combinational in-to-out path.

## Structure
- Shared package mips_pipe_pkg holds:
  - enum skid_state_t {EMPTY, ONE, FULL}, 2-bit encoding.
  - Occupancy width constant OCC_W=2.
- Sub-module flopenr_async: WIDTH-parameterised data flop with enable and asynchronous active-low clear. Instanced twice, for main and skid.
- The state register and next-state logic live in pipe_skid_reg.

## Test plan
- Reset then stream: all values below are hex. Hold out_ready=1 and drive in_data 11, 22, 33 on consecutive cycles. Required: out_data 11, 22, 33 on the next three cycles; in_ready stays 1; occupancy stays 1.
- Stall fill: in ONE holding AA, drop out_ready and offer BB, then CC. Required: BB is accepted, FULL, occupancy=2, in_ready=0; CC is held off. Then raise out_ready. Required: AA, BB, CC emerge in order.
- Drain: from FULL holding AA, BB, set in_valid=0 and out_ready=1 for 3 cycles. Required: AA, then BB, then out_valid=0 and occupancy=0.
- Flush with simultaneous events: from FULL, assert flush together with out_ready=1. Required: next cycle EMPTY, out_valid=0, in_ready=1; the subsequent input DD appears alone.
- Async reset: pulse reset low mid-cycle while FULL. Required: out_valid=0, out_data=0 and occupancy=0 before the next clock edge.
- Random valid/ready (10k cycles) with a scoreboard. Required: no loss, duplication or reorder, and no handshake-rule violation.
